// File: rtl/lite_arb.sv
// Two-requester arbiter in front of a single AXI-Lite write engine.
// Round-robin grants, optional lock to keep ownership, and a WAIT timeout.
module lite_arb #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    input  logic        r1_valid,
    input  logic        r0_lock,
    input  logic        r1_lock,
    input  logic [9:0]  r0_awaddr,
    input  logic [9:0]  r1_awaddr,
    input  logic [31:0] r0_wdata,
    input  logic [31:0] r1_wdata,
    output logic        r0_ready,
    output logic        r1_ready,
    output logic        r0_done,
    output logic        r1_done,
    output logic        r0_err,
    output logic        r1_err,
    output logic        lite_valid,
    output logic [9:0]  lite_awaddr,
    output logic [31:0] lite_wdata,
    input  logic        lite_end,
    output logic        busy,
    output logic        owner
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t        state;
    logic          last_grant;
    logic          owner_q;
    logic          cap_lock;
    logic [CW-1:0] cnt;
    logic          lite_valid_q;
    logic          done0_q, done1_q, err0_q, err1_q;
    logic          rdy0, rdy1;
    logic          accept;
    logic          win;
    logic          owner_lock;

    always_comb begin
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        unique case (state)
            IDLE: begin
                // On a tie, last_grant=1 means requester 0 goes next.
                if (r0_valid && (!r1_valid || last_grant)) rdy0 = 1'b1;
                else if (r1_valid)                         rdy1 = 1'b1;
            end
            HOLD: begin
                rdy0 = !owner_q && r0_valid;
                rdy1 = owner_q && r1_valid;
            end
            ISSUE, WAIT: begin
                rdy0 = 1'b0;
                rdy1 = 1'b0;
            end
        endcase
    end

    assign accept     = rdy0 | rdy1;
    assign win        = rdy1;
    assign owner_lock = owner_q ? r1_lock : r0_lock;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner_q      <= 1'b0;
            cap_lock     <= 1'b0;
            cnt          <= '0;
            lite_awaddr  <= '0;
            lite_wdata   <= '0;
            lite_valid_q <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            lite_valid_q <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            unique case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        lite_awaddr  <= win ? r1_awaddr : r0_awaddr;
                        lite_wdata   <= win ? r1_wdata : r0_wdata;
                        cap_lock     <= win ? r1_lock : r0_lock;
                        owner_q      <= win;
                        last_grant   <= win;
                        lite_valid_q <= 1'b1;
                        state        <= ISSUE;
                    end else if (state == HOLD && !owner_lock) begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A completion on the final timeout cycle still counts as success.
                    if (lite_end) begin
                        done0_q <= !owner_q;
                        done1_q <= owner_q;
                        state   <= cap_lock ? HOLD : IDLE;
                    end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        done0_q  <= !owner_q;
                        done1_q  <= owner_q;
                        err0_q   <= !owner_q;
                        err1_q   <= owner_q;
                        cap_lock <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign r0_ready   = rdy0 & ~rst;
    assign r1_ready   = rdy1 & ~rst;
    assign r0_done    = done0_q & ~rst;
    assign r1_done    = done1_q & ~rst;
    assign r0_err     = err0_q & ~rst;
    assign r1_err     = err1_q & ~rst;
    assign lite_valid = lite_valid_q & ~rst;
    assign busy       = (state != IDLE) & ~rst;
    assign owner      = owner_q;

endmodule

// File: tb/tb_lite_arb.sv
// Randomized bench for lite_arb: a transaction-timeline model schedules expected
// grants, commands and completions; a monitor pops and compares them.
module tb_lite_arb;

    localparam int T = 16;

    logic        clk;
    logic        rst;
    logic        r0_valid, r1_valid, r0_lock, r1_lock;
    logic [9:0]  r0_awaddr, r1_awaddr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err;
    logic        lite_valid;
    logic [9:0]  lite_awaddr;
    logic [31:0] lite_wdata;
    logic        lite_end;
    logic        busy;
    logic        owner;

    lite_arb #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_lock(r0_lock), .r1_lock(r1_lock),
        .r0_awaddr(r0_awaddr), .r1_awaddr(r1_awaddr),
        .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_done(r0_done), .r1_done(r1_done),
        .r0_err(r0_err), .r1_err(r1_err),
        .lite_valid(lite_valid), .lite_awaddr(lite_awaddr), .lite_wdata(lite_wdata),
        .lite_end(lite_end), .busy(busy), .owner(owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {logic [9:0] addr; logic [31:0] data; logic lock;} item_t;
    typedef struct {int cyc; logic [9:0] addr; logic [31:0] data;} lite_ev_t;
    typedef struct {int cyc; int idx; logic err;} done_ev_t;
    typedef struct {logic r0; logic r1; logic busy; logic own; logic zero;} cyc_exp_t;

    item_t    pend0[$], pend1[$];
    lite_ev_t lq[$];
    done_ev_t dq[$];
    cyc_exp_t eq[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Model state: arbiter accepts from free_at on; holder = locked owner or -1.
    int free_at = 0, holder = -1, last = 1, own_m = 0, prev_grant = -1;
    int end_cyc = -1, wait_first = 0, wait_last = -1;
    bit gen_on = 1'b1, rst_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic item_t rand_item();
        item_t it;
        it.addr = 10'($urandom);
        it.data = $urandom;
        it.lock = ($urandom_range(3) == 0);
        return it;
    endfunction

    task automatic step(input bit do_rst);
        item_t    it, tmp;
        cyc_exp_t e;
        lite_ev_t lt;
        done_ev_t dt;
        int       grant, d;
        bit       v0, v1, l0, l1, in_wait;
        @(posedge clk);
        #1;
        cyc++;
        if (prev_grant == 0) tmp = pend0.pop_front();
        else if (prev_grant == 1) tmp = pend1.pop_front();
        if (gen_on && pend0.size() == 0 && $urandom_range(2) == 0) pend0.push_back(rand_item());
        if (gen_on && pend1.size() == 0 && $urandom_range(2) == 0) pend1.push_back(rand_item());
        v0 = (pend0.size() != 0);
        v1 = (pend1.size() != 0);
        l0 = v0 ? pend0[0].lock : ($urandom_range(3) != 0);
        l1 = v1 ? pend1[0].lock : ($urandom_range(3) != 0);
        r0_valid  = v0;
        r1_valid  = v1;
        r0_lock   = l0;
        r1_lock   = l1;
        r0_awaddr = v0 ? pend0[0].addr : 10'($urandom);
        r1_awaddr = v1 ? pend1[0].addr : 10'($urandom);
        r0_wdata  = v0 ? pend0[0].data : $urandom;
        r1_wdata  = v1 ? pend1[0].data : $urandom;
        in_wait   = (cyc >= wait_first) && (cyc <= wait_last);
        lite_end  = (cyc == end_cyc) || (!in_wait && $urandom_range(7) == 0);
        rst       = do_rst;

        e = '{r0: 1'b0, r1: 1'b0, busy: 1'b0, own: 1'b0, zero: 1'b0};
        grant = -1;
        if (do_rst) begin
            e.zero = rst_prev;
            e.own  = rst_prev ? 1'b0 : 1'(own_m);
            while (lq.size() != 0 && lq[$].cyc >= cyc) lt = lq.pop_back();
            while (dq.size() != 0 && dq[$].cyc >= cyc) dt = dq.pop_back();
            free_at = cyc + 1; holder = -1; last = 1; own_m = 0;
            end_cyc = -1; wait_last = -1;
        end else begin
            e.busy = !(cyc >= free_at && holder < 0);
            e.own  = 1'(own_m);
            if (cyc >= free_at) begin
                if (holder < 0) begin
                    if (v0 && v1) grant = 1 - last;
                    else if (v0)  grant = 0;
                    else if (v1)  grant = 1;
                end else if (holder == 0 ? v0 : v1) begin
                    grant = holder;
                end else if (!(holder == 0 ? l0 : l1)) begin
                    holder = -1;
                end
            end
            if (grant >= 0) begin
                it    = (grant == 0) ? pend0[0] : pend1[0];
                e.r0  = (grant == 0);
                e.r1  = (grant == 1);
                last  = grant;
                own_m = grant;
                lq.push_back('{cyc: cyc + 1, addr: it.addr, data: it.data});
                case ($urandom_range(9))
                    0:       d = T + 1;
                    1:       d = T;
                    default: d = $urandom_range(5, 1);
                endcase
                wait_first = cyc + 2;
                if (d > T) begin
                    end_cyc   = -1;
                    wait_last = cyc + 1 + T;
                    free_at   = cyc + 2 + T;
                    holder    = -1;
                    dq.push_back('{cyc: cyc + 2 + T, idx: grant, err: 1'b1});
                end else begin
                    end_cyc   = cyc + 1 + d;
                    wait_last = end_cyc;
                    free_at   = end_cyc + 1;
                    holder    = it.lock ? grant : -1;
                    dq.push_back('{cyc: end_cyc + 1, idx: grant, err: 1'b0});
                end
            end
        end
        rst_prev   = do_rst;
        prev_grant = grant;
        eq.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the scheduled expectations.
    initial begin
        cyc_exp_t e;
        lite_ev_t lt;
        done_ev_t dt;
        logic [3:0] dv;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (eq.size() != 0) begin
                e = eq.pop_front();
                check("ready", {62'd0, r1_ready, r0_ready}, {62'd0, e.r1, e.r0});
                check("busy", {63'd0, busy}, {63'd0, e.busy});
                check("owner", {63'd0, owner}, {63'd0, e.own});
                if (e.zero) check("reset_regs", {22'd0, lite_awaddr, lite_wdata}, 64'd0);
            end
            if (lq.size() != 0 && lq[0].cyc < cyc) begin
                lt = lq.pop_front();
                check("lite_valid_missing", 64'd0, {32'd0, lt.cyc});
            end
            if (dq.size() != 0 && dq[0].cyc < cyc) begin
                dt = dq.pop_front();
                check("done_missing", 64'd0, {32'd0, dt.cyc});
            end
            if (lite_valid) begin
                if (lq.size() == 0) begin
                    check("lite_valid_unexpected", 64'd1, 64'd0);
                end else begin
                    lt = lq.pop_front();
                    check("lite_cmd", {cyc[21:0], lite_awaddr, lite_wdata},
                          {lt.cyc[21:0], lt.addr, lt.data});
                end
            end
            dv = {r1_err, r0_err, r1_done, r0_done};
            if (dv != 4'b0000) begin
                if (dq.size() == 0) begin
                    check("done_unexpected", {60'd0, dv}, 64'd0);
                end else begin
                    dt = dq.pop_front();
                    check("done", {cyc[31:0], 28'd0, dv},
                          {dt.cyc[31:0], 28'd0,
                           (dt.idx == 1) & dt.err, (dt.idx == 0) & dt.err,
                           dt.idx == 1, dt.idx == 0});
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; r0_lock = 1'b0; r1_lock = 1'b0;
        r0_awaddr = '0; r1_awaddr = '0; r0_wdata = '0; r1_wdata = '0;
        lite_end = 1'b0;
        pend0.push_back('{addr: 10'h048, data: 32'h1000_0000, lock: 1'b0});
        pend1.push_back('{addr: 10'h030, data: 32'h0000_0001, lock: 1'b0});
        repeat (3) step(1'b1);
        for (int i = 0; i < 3000; i++) step($urandom_range(199) == 0);
        gen_on = 1'b0;
        for (int i = 0; i < 80; i++) step(1'b0);
        @(negedge clk);
        #1;
        check("lite_queue_drained", {32'd0, lq.size()}, 64'd0);
        check("done_queue_drained", {32'd0, dq.size()}, 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
